// File: rtl/button_event_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_if
//  Description : Key-event valid/ready channel from button_event to the
//                calculator core. Carries the button index, the repeat flag
//                and the overflow (drop) strobe.
//  Revision    : 1.0  initial release
// ============================================================================
interface button_event_if #(
  parameter int CODE_W = 3
);
  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;
  logic              evt_repeat;
  logic              evt_drop;

  // Event producer
  modport master (
    output evt_valid,
    output evt_code,
    output evt_repeat,
    output evt_drop,
    input  evt_ready
  );

  // Event consumer
  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_repeat,
    input  evt_drop,
    output evt_ready
  );
endinterface
`default_nettype wire

// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
//  Module      : button_event
//  Description : Turns debounced button levels into key events. One event per
//                fresh press (lowest index wins), then auto-repeat events while
//                the owning button stays held. Single-entry output slot with a
//                valid/ready handshake; events that find the slot full are
//                dropped and flagged with a one-cycle evt_drop pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module button_event #(
  parameter int          N_BTN    = 5,
  parameter int          CODE_W   = 3,
  parameter logic [31:0] HOLD_DLY = 32'd49_999_999,
  parameter logic [31:0] RPT_PER  = 32'd9_999_999
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [N_BTN-1:0] deb,
  button_event_if.master        evt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [CODE_W-1:0] owner_q, owner_d;
  logic [N_BTN-1:0]  deb_q;

  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              repeat_q, repeat_d;
  logic              drop_q, drop_d;

  logic [N_BTN-1:0]  rise;
  logic [CODE_W-1:0] rise_idx;
  logic              emit;
  logic              emit_rep;
  logic [CODE_W-1:0] emit_code;

  assign rise = deb & ~deb_q;

  // Lowest set index of the rising-edge vector (downward scan so the lowest wins)
  always_comb begin
    rise_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = CODE_W'(i);
    end
  end

  // Press/hold/repeat sequencing: next state, counter and event request
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    emit      = 1'b0;
    emit_rep  = 1'b0;
    emit_code = owner_q;
    case (state_q)
      S_IDLE: begin
        if (|rise) begin
          owner_d   = rise_idx;
          emit      = 1'b1;
          emit_code = rise_idx;
          cnt_d     = '0;
          state_d   = S_HELD;
        end
      end
      S_HELD: begin
        // Release is checked first so it beats a coincident threshold
        if (!deb[owner_q]) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == HOLD_DLY - 32'd1) begin
          emit     = 1'b1;
          emit_rep = 1'b1;
          cnt_d    = '0;
          state_d  = S_REPEAT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_REPEAT: begin
        if (!deb[owner_q]) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == RPT_PER - 32'd1) begin
          emit     = 1'b1;
          emit_rep = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output slot: load when free or being accepted, otherwise drop and flag
  always_comb begin
    valid_d  = valid_q;
    code_d   = code_q;
    repeat_d = repeat_q;
    drop_d   = 1'b0;
    if (emit) begin
      if (!valid_q || evt.evt_ready) begin
        valid_d  = 1'b1;
        code_d   = emit_code;
        repeat_d = emit_rep;
      end else begin
        drop_d = 1'b1;
      end
    end else if (valid_q && evt.evt_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; deb_q resets high so a held button needs a re-press
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      owner_q  <= '0;
      deb_q    <= '1;
      valid_q  <= 1'b0;
      code_q   <= '0;
      repeat_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      deb_q    <= deb;
      valid_q  <= valid_d;
      code_q   <= code_d;
      repeat_q <= repeat_d;
      drop_q   <= drop_d;
    end
  end

  assign evt.evt_valid  = valid_q;
  assign evt.evt_code   = code_q;
  assign evt.evt_repeat = repeat_q;
  assign evt.evt_drop   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event
//  Description : Randomized and directed stimulus for button_event with a
//                time-since-press reference model and a scoreboard monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_event;

  localparam int N_BTN  = 5;
  localparam int CODE_W = 3;
  localparam int HOLD   = 10;
  localparam int RPT    = 4;

  typedef struct {
    logic [CODE_W-1:0] code;
    logic              rep;
  } evt_t;

  typedef struct {
    logic v;
    logic d;
  } cyc_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] deb;

  button_event_if #(.CODE_W(CODE_W)) evt_if ();

  button_event #(
    .N_BTN   (N_BTN),
    .CODE_W  (CODE_W),
    .HOLD_DLY(32'(HOLD)),
    .RPT_PER (32'(RPT))
  ) dut (
    .clk(clk),
    .rst(rst),
    .deb(deb),
    .evt(evt_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  evt_t evq[$];
  cyc_t cycq[$];

  // Reference model state, expressed as time since the press event
  logic             m_valid;
  logic [N_BTN-1:0] m_prev;
  bit               m_owned;
  int               m_owner;
  int               m_age;

  // Apply inputs for the next rising edge and predict that edge's outcome
  task automatic drive(input logic r, input logic [N_BTN-1:0] d, input logic rdy);
    bit               em;
    evt_t             e;
    cyc_t             c;
    logic [N_BTN-1:0] rise;
    rst = r;
    deb = d;
    evt_if.evt_ready = rdy;
    em = 0;
    e.code = '0;
    e.rep = 1'b0;
    c.d = 1'b0;
    if (r) begin
      m_valid = 1'b0;
      m_prev  = '1;
      m_owned = 0;
      m_age   = 0;
      evq.delete();
    end else begin
      rise = d & ~m_prev;
      if (!m_owned) begin
        for (int i = 0; i < N_BTN; i++) begin
          if (rise[i]) begin
            m_owner = i;
            m_owned = 1;
            m_age   = 0;
            em      = 1;
            e.code  = CODE_W'(i);
            e.rep   = 1'b0;
            break;
          end
        end
      end else if (!d[m_owner]) begin
        m_owned = 0;
      end else begin
        m_age++;
        if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % RPT == 0)) begin
          em     = 1;
          e.code = CODE_W'(m_owner);
          e.rep  = 1'b1;
        end
      end
      m_prev = d;
      if (em) begin
        if (!m_valid || rdy) begin
          evq.push_back(e);
          m_valid = 1'b1;
        end else begin
          c.d = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    c.v = m_valid;
    cycq.push_back(c);
  endtask

  task automatic cyc(input logic r, input logic [N_BTN-1:0] d, input logic rdy, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      drive(r, d, rdy);
    end
  endtask

  // Monitor: compare each edge's outcome and the offered event against the scoreboard
  initial begin
    cyc_t c;
    evt_t e;
    forever begin
      @(negedge clk);
      if (cycq.size() > 0) begin
        c = cycq.pop_front();
        checks++;
        if (evt_if.evt_valid !== c.v) begin
          failures++;
          $display("FAIL valid t=%0t got=%b exp=%b", $time, evt_if.evt_valid, c.v);
        end
        checks++;
        if (evt_if.evt_drop !== c.d) begin
          failures++;
          $display("FAIL drop t=%0t got=%b exp=%b", $time, evt_if.evt_drop, c.d);
        end
        if (evt_if.evt_valid === 1'b1 && !rst) begin
          checks++;
          if (evq.size() == 0) begin
            failures++;
            $display("FAIL event t=%0t got code=%0d rep=%b exp=none", $time,
                     evt_if.evt_code, evt_if.evt_repeat);
          end else begin
            e = evq[0];
            if (evt_if.evt_code !== e.code || evt_if.evt_repeat !== e.rep) begin
              failures++;
              $display("FAIL event t=%0t got code=%0d rep=%b exp code=%0d rep=%b", $time,
                       evt_if.evt_code, evt_if.evt_repeat, e.code, e.rep);
            end
            if (evt_if.evt_ready === 1'b1) void'(evq.pop_front());
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by random button activity
  initial begin
    logic [N_BTN-1:0] d;
    logic             r;
    logic             rdy;
    int               wait_cyc;
    m_owner = 0;
    drive(1'b1, '0, 1'b1);
    cyc(1'b1, '0, 1'b1, 2);
    cyc(1'b0, '0, 1'b1, 3);
    // single short press
    cyc(1'b0, 5'b00100, 1'b1, 3);
    cyc(1'b0, 5'b00000, 1'b1, 5);
    // long hold with repeats
    cyc(1'b0, 5'b00001, 1'b1, 30);
    cyc(1'b0, 5'b00000, 1'b1, 5);
    // simultaneous press, lowest wins; other held button needs a re-press
    cyc(1'b0, 5'b10010, 1'b1, 3);
    cyc(1'b0, 5'b10000, 1'b1, 3);
    cyc(1'b0, 5'b00000, 1'b1, 2);
    cyc(1'b0, 5'b10000, 1'b1, 3);
    cyc(1'b0, 5'b00000, 1'b1, 3);
    // held through reset, then release and press
    cyc(1'b1, 5'b01000, 1'b1, 3);
    cyc(1'b0, 5'b01000, 1'b1, 5);
    cyc(1'b0, 5'b00000, 1'b1, 2);
    cyc(1'b0, 5'b01000, 1'b1, 2);
    cyc(1'b0, 5'b00000, 1'b1, 2);
    // slot full: second press dropped
    cyc(1'b0, 5'b00001, 1'b0, 2);
    cyc(1'b0, 5'b00000, 1'b0, 2);
    cyc(1'b0, 5'b01000, 1'b0, 2);
    cyc(1'b0, 5'b00000, 1'b0, 1);
    cyc(1'b0, 5'b00000, 1'b1, 3);
    // release exactly at the hold threshold
    cyc(1'b0, 5'b00001, 1'b1, HOLD);
    cyc(1'b0, 5'b00000, 1'b1, 3);
    // reset with an event pending
    cyc(1'b0, 5'b00001, 1'b0, 2);
    cyc(1'b1, 5'b00000, 1'b0, 1);
    cyc(1'b0, 5'b00000, 1'b1, 3);
    // random activity
    d = '0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(7) == 0) d[$urandom_range(N_BTN - 1)] ^= 1'b1;
      rdy = ($urandom_range(3) != 0);
      r   = ($urandom_range(299) == 0);
      cyc(r, d, rdy, 1);
    end
    cyc(1'b0, '0, 1'b1, 20);
    wait_cyc = 0;
    while (cycq.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (cycq.size() != 0 || evq.size() != 0) begin
      failures++;
      $display("FAIL drain got cyc=%0d evt=%0d exp cyc=0 evt=0", cycq.size(), evq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
